killer_update_ctrl: RTL and testbench

KILLER_UPDATE_CTRL -- requirements
Module: killer_update_ctrl

---
 rtl/killer_update_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_killer_update_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/killer_update_ctrl.sv
// rtl/killer_update_ctrl.sv - killer-move update sequencer with request queue and clear handling
`ifndef BOARD_WIDTH
`define BOARD_WIDTH 64
`endif

module killer_update_ctrl #(
   parameter int MAX_DEPTH_LOG2  = 0,
   parameter int SETUP_CYCLES    = 3,
   parameter int PULSE_CYCLES    = 2,
   parameter int GAP_CYCLES      = 1,
   parameter int FIFO_DEPTH_LOG2 = 2,
   // ply width falls back to one bit while the depth parameter is left at its unset default
   localparam int PLY_W = (MAX_DEPTH_LOG2 > 0) ? MAX_DEPTH_LOG2 : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [PLY_W-1:0]        req_ply,
   input  logic [`BOARD_WIDTH-1:0] req_board,
   input  logic                    clear_req,
   output logic [PLY_W-1:0]        killer_ply,
   output logic [`BOARD_WIDTH-1:0] killer_board,
   output logic                    killer_update,
   output logic                    killer_clear,
   output logic                    busy,
   output logic [7:0]              drop_count
);

   localparam int BW      = `BOARD_WIDTH;
   localparam int ENTRY_W = PLY_W + BW;
   localparam int DEPTH   = 1 << FIFO_DEPTH_LOG2;
   localparam int PTR_W   = (FIFO_DEPTH_LOG2 > 0) ? FIFO_DEPTH_LOG2 : 1;
   localparam int CNT_W   = FIFO_DEPTH_LOG2 + 1;
   localparam int MAX_T   = (SETUP_CYCLES > PULSE_CYCLES) ?
                            ((SETUP_CYCLES > GAP_CYCLES) ? SETUP_CYCLES : GAP_CYCLES) :
                            ((PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES);
   localparam int TMR_W   = $clog2(MAX_T + 1);
   localparam int SUM_W   = CNT_W + 9;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_PULSE,
      S_GAP,
      S_CLR_PULSE,
      S_CLR_GAP
   } state_t;

   state_t             state, state_n;
   logic [TMR_W-1:0]   tmr, tmr_n;
   logic               clr_pending;
   logic               ready_en;
   logic               push, pop, load, abort, clr_enter;
   logic               full;

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   rd_ptr, wr_ptr, wr_addr;
   logic [CNT_W-1:0]   fifo_count;
   logic [PLY_W-1:0]   head_ply;
   logic [BW-1:0]      head_board;
   logic [SUM_W-1:0]   drop_sum;

   assign full      = (fifo_count == CNT_W'(DEPTH));
   assign req_ready = ready_en && !full;
   assign push      = req_valid && req_ready;
   // a clear empties the queue, so a request arriving with it lands in slot 0
   assign wr_addr   = clear_req ? '0 : wr_ptr;
   assign {head_ply, head_board} = mem[rd_ptr];
   assign busy      = (state != S_IDLE) || (fifo_count != '0) || clr_pending;
   // entries flushed by the clear plus the request aborted out of SETUP
   assign drop_sum  = SUM_W'(drop_count) + SUM_W'(fifo_count) + SUM_W'(abort);

   // request acceptance opens on the first edge after reset release
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) ready_en <= 1'b0;
      else        ready_en <= 1'b1;
   end

   // queue storage; contents are don't-care while the pointers say empty
   always_ff @(posedge clk) begin
      if (push) mem[wr_addr] <= {req_ply, req_board};
   end

   // queue pointers and occupancy, with flush on clear keeping any same-cycle push
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_count <= '0;
      end else if (clear_req) begin
         rd_ptr     <= '0;
         wr_ptr     <= push ? PTR_W'(1) : '0;
         fifo_count <= push ? CNT_W'(1) : '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // next-state, shared timer and queue-pop decisions
   always_comb begin
      state_n   = state;
      tmr_n     = tmr;
      pop       = 1'b0;
      load      = 1'b0;
      abort     = 1'b0;
      clr_enter = 1'b0;
      case (state)
         S_IDLE: begin
            if (clr_pending || clear_req) begin
               state_n   = S_CLR_PULSE;
               tmr_n     = TMR_W'(PULSE_CYCLES - 1);
               clr_enter = 1'b1;
            end else if (fifo_count != '0) begin
               pop     = 1'b1;
               load    = 1'b1;
               state_n = S_SETUP;
               tmr_n   = TMR_W'(SETUP_CYCLES - 1);
            end
         end
         S_SETUP: begin
            if (clear_req) begin
               state_n = S_IDLE;
               abort   = 1'b1;
            end else if (tmr == '0) begin
               state_n = S_PULSE;
               tmr_n   = TMR_W'(PULSE_CYCLES - 1);
            end else begin
               tmr_n = tmr - TMR_W'(1);
            end
         end
         S_PULSE: begin
            if (tmr == '0) begin
               state_n = S_GAP;
               tmr_n   = TMR_W'(GAP_CYCLES - 1);
            end else begin
               tmr_n = tmr - TMR_W'(1);
            end
         end
         S_GAP: begin
            if (tmr == '0) state_n = S_IDLE;
            else           tmr_n   = tmr - TMR_W'(1);
         end
         S_CLR_PULSE: begin
            if (tmr == '0) begin
               state_n = S_CLR_GAP;
               tmr_n   = TMR_W'(GAP_CYCLES - 1);
            end else begin
               tmr_n = tmr - TMR_W'(1);
            end
         end
         S_CLR_GAP: begin
            if (tmr == '0) state_n = S_IDLE;
            else           tmr_n   = tmr - TMR_W'(1);
         end
         default: state_n = S_IDLE;
      endcase
   end

   // state, timer and pulse outputs registered from the next state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= S_IDLE;
         tmr           <= '0;
         killer_update <= 1'b0;
         killer_clear  <= 1'b0;
      end else begin
         state         <= state_n;
         tmr           <= tmr_n;
         killer_update <= (state_n == S_PULSE);
         killer_clear  <= (state_n == S_CLR_PULSE);
      end
   end

   // sticky clear request, consumed when the clear pulse starts
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)         clr_pending <= 1'b0;
      else if (clr_enter) clr_pending <= 1'b0;
      else if (clear_req) clr_pending <= 1'b1;
   end

   // ply/board held from load until the next load
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         killer_ply   <= '0;
         killer_board <= '0;
      end else if (load) begin
         killer_ply   <= head_ply;
         killer_board <= head_board;
      end
   end

   // saturating tally of requests thrown away by clears
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)         drop_count <= 8'd0;
      else if (clear_req) drop_count <= (drop_sum > SUM_W'(255)) ? 8'd255 : drop_sum[7:0];
   end

endmodule

// File: tb/tb_killer_update_ctrl.sv
// tb/tb_killer_update_ctrl.sv - scoreboard bench for killer_update_ctrl
`ifndef BOARD_WIDTH
`define BOARD_WIDTH 64
`endif

module tb_killer_update_ctrl;

   localparam int PW    = 4;
   localparam int BW    = `BOARD_WIDTH;
   localparam int SETUP = 3;
   localparam int PULSE = 2;
   localparam int GAP   = 1;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          req_valid = 1'b0;
   logic          clear_req = 1'b0;
   logic [PW-1:0] req_ply = '0;
   logic [BW-1:0] req_board = '0;
   logic          req_ready;
   logic [PW-1:0] killer_ply;
   logic [BW-1:0] killer_board;
   logic          killer_update;
   logic          killer_clear;
   logic          busy;
   logic [7:0]    drop_count;

   int checks = 0;
   int passes = 0;
   int model_drops = 0;
   bit saw_full = 0;

   typedef struct {
      bit            is_clear;
      logic [PW-1:0] ply;
      logic [BW-1:0] board;
   } ev_t;

   ev_t exp_q[$];

   always #5 clk = ~clk;

   killer_update_ctrl #(
      .MAX_DEPTH_LOG2 (PW),
      .SETUP_CYCLES   (SETUP),
      .PULSE_CYCLES   (PULSE),
      .GAP_CYCLES     (GAP),
      .FIFO_DEPTH_LOG2(2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_ply      (req_ply),
      .req_board    (req_board),
      .clear_req    (clear_req),
      .killer_ply   (killer_ply),
      .killer_board (killer_board),
      .killer_update(killer_update),
      .killer_clear (killer_clear),
      .busy         (busy),
      .drop_count   (drop_count)
   );

   function automatic void check(string name, logic [BW-1:0] act, logic [BW-1:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, req);
   endfunction

   // monitor: pops the expected event at each pulse start and checks pulse shape
   int  up_len = 0, clr_len = 0, low_since_up = 0;
   bit  seen_up = 0, cur_ok = 0;
   ev_t cur;

   always @(negedge clk) begin
      if (!reset) begin
         up_len = 0; clr_len = 0; low_since_up = 0; seen_up = 0; cur_ok = 0;
      end else begin
         if (killer_update && killer_clear) check("update_clear_overlap", 1, 0);
         if (killer_update) begin
            if (up_len == 0) begin
               if (seen_up) check("update_low_gap_ge4", BW'(low_since_up >= SETUP + GAP), 1);
               if (exp_q.size() == 0) begin
                  check("unexpected_update", 1, 0);
                  cur_ok = 0;
               end else begin
                  cur = exp_q.pop_front();
                  check("update_kind", BW'(cur.is_clear), 0);
                  cur_ok = !cur.is_clear;
               end
            end
            if (cur_ok) begin
               check("update_ply", BW'(killer_ply), BW'(cur.ply));
               check("update_board", killer_board, cur.board);
            end
            up_len++;
         end else begin
            if (up_len != 0) begin
               check("update_len", BW'(up_len), BW'(PULSE));
               seen_up = 1;
               low_since_up = 0;
            end
            up_len = 0;
            low_since_up++;
         end
         if (killer_clear) begin
            if (clr_len == 0) begin
               if (exp_q.size() == 0) check("unexpected_clear", 1, 0);
               else begin
                  cur = exp_q.pop_front();
                  check("clear_kind", BW'(cur.is_clear), 1);
                  cur_ok = 0;
               end
            end
            clr_len++;
         end else begin
            if (clr_len != 0) check("clear_len", BW'(clr_len), BW'(PULSE));
            clr_len = 0;
         end
      end
   end

   // present a request from the current negedge until accepted; returns one negedge after acceptance
   task automatic send(input logic [PW-1:0] p, input logic [BW-1:0] b);
      int n = 0;
      req_valid = 1'b1;
      req_ply   = p;
      req_board = b;
      while (!req_ready && n < 100) begin
         saw_full = 1;
         @(negedge clk);
         n++;
      end
      if (!req_ready) check("send_timeout", 0, 1);
      else exp_q.push_back('{1'b0, p, b});
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || killer_update || killer_clear) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("idle_reached", BW'(busy), 0);
      repeat (2) @(negedge clk);
   endtask

   function automatic logic [BW-1:0] rnd_board();
      return BW'({$urandom, $urandom});
   endfunction

   logic [BW-1:0] b;

   initial begin
      // reset state
      repeat (2) @(negedge clk);
      check("rst_ready", BW'(req_ready), 0);
      check("rst_busy", BW'(busy), 0);
      check("rst_update", BW'(killer_update), 0);
      check("rst_clear", BW'(killer_clear), 0);
      check("rst_ply", BW'(killer_ply), 0);
      check("rst_board", killer_board, 0);
      check("rst_drop", BW'(drop_count), 0);
      reset = 1'b1;
      @(negedge clk);
      check("ready_after_release", BW'(req_ready), 1);

      // single request, cycle-exact timing
      b = rnd_board();
      send(4'd5, b);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (k == 1) begin
            check("single_ply_c1", BW'(killer_ply), 5);
            check("single_board_c1", killer_board, b);
         end
         check("single_update_timing", BW'(killer_update), BW'(k == 4 || k == 5));
         if (k == 7) check("single_busy_c7", BW'(busy), 0);
      end
      wait_idle();

      // back-to-back burst fills the queue; order checked by the monitor
      saw_full = 0;
      for (int i = 0; i < 6 + $urandom_range(0, 3); i++) send(PW'($urandom_range(0, 15)), rnd_board());
      check("ready_low_when_full", BW'(saw_full), 1);
      wait_idle();

      // random spacing
      for (int i = 0; i < 20; i++) begin
         send(PW'($urandom_range(0, 15)), rnd_board());
         repeat ($urandom_range(0, 6)) @(negedge clk);
      end
      wait_idle();

      // clear during SETUP of the first of three queued requests
      for (int i = 0; i < 3; i++) send(PW'($urandom_range(0, 15)), rnd_board());
      clear_req = 1'b1;
      @(negedge clk);
      clear_req = 1'b0;
      repeat (3) void'(exp_q.pop_back());
      exp_q.push_back('{1'b1, '0, '0});
      model_drops += 3;
      wait_idle();
      check("drop_after_setup_clear", BW'(drop_count), BW'(model_drops));

      // three clears while an update is pulsing
      send(PW'($urandom_range(0, 15)), rnd_board());
      exp_q.push_back('{1'b1, '0, '0});
      repeat (4) @(negedge clk);
      check("in_pulse_c4", BW'(killer_update), 1);
      clear_req = 1'b1;
      repeat (3) @(negedge clk);
      clear_req = 1'b0;
      wait_idle();
      check("drop_after_pulse_clear", BW'(drop_count), BW'(model_drops));

      // clear together with an accepted request: clear first, request kept
      exp_q.push_back('{1'b1, '0, '0});
      clear_req = 1'b1;
      send(PW'($urandom_range(0, 15)), rnd_board());
      clear_req = 1'b0;
      wait_idle();
      check("drop_after_joint_clear", BW'(drop_count), BW'(model_drops));

      // reset mid-pulse with two entries queued
      for (int i = 0; i < 3; i++) send(PW'($urandom_range(0, 15)), rnd_board());
      repeat (2) @(negedge clk);
      check("pre_reset_pulse", BW'(killer_update), 1);
      #1 reset = 1'b0;
      #1;
      check("async_update_drop", BW'(killer_update), 0);
      exp_q.delete();
      model_drops = 0;
      repeat (2) @(negedge clk);
      check("in_reset_ready", BW'(req_ready), 0);
      reset = 1'b1;
      @(negedge clk);
      check("post_reset_ready", BW'(req_ready), 1);
      repeat (30) @(negedge clk);
      check("post_reset_busy", BW'(busy), 0);
      check("post_reset_drop", BW'(drop_count), BW'(model_drops));

      check("scoreboard_empty", BW'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
